// File: rtl/pipelined_add_sub_if.sv
// Operand/result bundle with valid/ready handshakes for the pipelined add/subtract unit.
interface pipelined_add_sub_if #(
   parameter int L = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [L-1:0] a;
   logic [L-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [L-1:0] s;
   logic         carry;
   logic         overflow;
   logic         zero;
   logic         negative;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, s, carry, overflow, zero, negative
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, s, carry, overflow, zero, negative
   );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined ripple add/subtract: each stage adds one CW-bit chunk and hands its carry to the next.
// The whole pipe advances together whenever the output slot is empty or being consumed.
module pipelined_add_sub #(
   parameter int L      = 16,
   parameter int STAGES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   pipelined_add_sub_if.slave bus
);
   localparam int CW = L / STAGES;

   if (L < 2 || STAGES < 1 || STAGES > L || (L % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_add_sub: illegal configuration L=%0d STAGES=%0d", L, STAGES);
   end

   logic en;

   assign en           = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = en;

   // Per-bit full-adder ripple over one chunk; returns {carry_out, sum}.
   function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x,
                                             input logic [CW-1:0] y,
                                             input logic          cin);
      logic          c;
      logic [CW-1:0] r;
      c = cin;
      r = '0;
      for (int i = 0; i < CW; i++) begin
         r[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | ((x[i] ^ y[i]) & c);
      end
      return {c, r};
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * CW;
      localparam int SW = LO + CW;

      logic [L-LO-1:0] in_a;
      logic [L-LO-1:0] in_b;
      logic            in_c;
      logic            in_v;
      logic [CW:0]     chunk;
      logic [SW-1:0]   nxt_s;
      logic [SW-1:0]   sum_q;
      logic            carry_q;
      logic            valid_q;

      assign chunk = add_chunk(in_a[CW-1:0], in_b[CW-1:0], in_c);

      // Subtraction is A + ~B + 1, so the inverted operand and the carry-in enter here.
      if (k == 0) begin : g_head
         assign in_a  = bus.a;
         assign in_b  = bus.sub ? ~bus.b : bus.b;
         assign in_c  = bus.sub;
         assign in_v  = bus.in_valid;
         assign nxt_s = chunk[CW-1:0];
      end else begin : g_body
         assign in_a  = g_stage[k-1].g_fwd.opa_q;
         assign in_b  = g_stage[k-1].g_fwd.opb_q;
         assign in_c  = g_stage[k-1].carry_q;
         assign in_v  = g_stage[k-1].valid_q;
         assign nxt_s = {chunk[CW-1:0], g_stage[k-1].sum_q};
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
         end else if (en) begin
            valid_q <= in_v;
            sum_q   <= nxt_s;
            carry_q <= chunk[CW];
         end
      end

      // Only the operand bits still waiting to be added travel to the next stage.
      if (k < STAGES - 1) begin : g_fwd
         logic [L-SW-1:0] opa_q;
         logic [L-SW-1:0] opb_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               opa_q <= '0;
               opb_q <= '0;
            end else if (en) begin
               opa_q <= in_a[L-LO-1:CW];
               opb_q <= in_b[L-LO-1:CW];
            end
         end
      end

      // Carry into the MSB is recovered as a^b^s at that bit, giving signed overflow.
      if (k == STAGES - 1) begin : g_tail
         logic overflow_q;
         logic zero_q;
         logic negative_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               overflow_q <= 1'b0;
               zero_q     <= 1'b0;
               negative_q <= 1'b0;
            end else if (en) begin
               overflow_q <= in_a[CW-1] ^ in_b[CW-1] ^ chunk[CW-1] ^ chunk[CW];
               zero_q     <= (nxt_s == '0);
               negative_q <= chunk[CW-1];
            end
         end

         assign bus.out_valid = valid_q;
         assign bus.s         = sum_q;
         assign bus.carry     = carry_q;
         assign bus.overflow  = overflow_q;
         assign bus.zero      = zero_q;
         assign bus.negative  = negative_q;
      end
   end
endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined add/subtract unit. Successor to the combinational ripple adder in the ALU.
- Splits an L-bit ripple add into STAGES registered chunks, so wide operands close timing at the core clock.
- Adds a subtract mode and full status flags (carry/borrow, signed overflow, zero, negative).
- Uses a valid/ready handshake so it can sit between the decode/issue stage and writeback with backpressure.

Parameters:
L, 16, operand and result width in bits; L >= 2
STAGES, 4, number of pipeline stages; 1 <= STAGES <= L and L % STAGES == 0; chunk width CW = L/STAGES

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode present
in_ready  output  1  unit accepts operands this cycle
a  input  L  operand A
b  input  L  operand B
sub  input  1  0: S=A+B; 1: S=A-B
out_valid  output  1  result and flags present
out_ready  input  1  consumer accepts result this cycle
s  output  L  result, modulo 2^L
carry  output  1  carry out of bit L-1; for sub: 1 = no borrow (A>=B unsigned)
overflow  output  1  signed two's-complement overflow
zero  output  1  s == 0
negative  output  1  s[L-1]

Behaviour:
- Reset:
  - rst_n low clears every stage valid bit immediately (asynchronous).
  - out_valid=0; s, carry, overflow, zero and negative are 0.
  - Datapath registers are cleared to 0.
  - Any operations in flight are discarded and never emitted.
- Advance enable: en = !out_valid | out_ready. in_ready = en, combinationally.
  - When en=1, every stage shifts forward by one, including bubbles.
  - When en=0, all stages and outputs hold; s and flags stay stable while out_valid=1 and out_ready=0.
- Accept: a transfer occurs when in_valid & in_ready.
  - Stage 0 captures A, B' = sub ? ~B : B, and Cin = sub.
  - Stage 0 computes chunk 0 (bits CW-1:0) as a ripple of per-bit full adders (S=a^b^c, Cout=ab|(a^b)c) and registers the partial sum plus chunk carry.
  - Stage k (1..STAGES-1) adds chunk k of the carried A/B' using the registered carry from stage k-1.
  - Unused operand bits are carried along unchanged.
- Latency: result appears on s with out_valid=1 exactly STAGES enabled cycles after acceptance. With no stalls, STAGES clock cycles.
- Throughput: one operation per cycle when out_ready stays high. Order is strictly preserved; no drops, no duplication.
- A transfer with in_valid=0 while en=1 inserts a bubble; the bubble's valid=0 propagates to out_valid.
- Flags are computed in the last stage from its chunk:
  - carry = carry out of bit L-1.
  - overflow = (carry into bit L-1) XOR (carry out of bit L-1).
  - zero = (s == 0).
  - negative = s[L-1].
- STAGES=1 degenerates to a single registered full-width adder with latency 1.
- Simultaneous output consume and input accept in the same cycle is legal and sustains full rate.
- sub is per-operation and travels with its operands; mixing add and sub back to back is legal.
- Out-of-range parameters (L % STAGES != 0) are a configuration error. Elaboration must fail via a generate-time check.

Test Plan (L=16, STAGES=4):
- Add overflow: a=0x7FFF, b=0x0001, sub=0 -> after 4 cycles: out_valid=1, s=0x8000, carry=0, overflow=1, zero=0, negative=1.
- Add wrap: a=0xFFFF, b=0x0001, sub=0 -> s=0x0000, carry=1, overflow=0, zero=1, negative=0.
- Subtract equal: a=0x0005, b=0x0005, sub=1 -> s=0x0000, carry=1 (no borrow), overflow=0, zero=1. Subtract overflow: a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, carry=1, overflow=1, negative=0.
- Streaming with backpressure: issue 6 back-to-back ops (a=i, b=0x0100, alternating sub), out_ready=1 for 2 results then 0 for 5 cycles, then 1:
  - in_ready drops the same cycle out_valid=1 & out_ready=0.
  - s and flags are held stable.
  - All 6 results arrive in order with correct values (e.g. i=1 add -> 0x0101; i=2 sub -> 0xFF02, carry=0).
- Reset mid-operation: accept 3 ops, drop rst_n for 1 cycle asynchronously between clock edges -> out_valid=0 and outputs 0 immediately; after release no stale result ever appears; a fresh op completes in 4 cycles.
- Bubble handling: accept op, idle 2 cycles, accept op -> out_valid high on cycles 4 and 7 only, low in between.
